adder12s_avg_out: RTL and testbench
===================================

Name: adder12s_avg_out

Overview:
Downstream consumer of the 8-input 12-bit pipelined adder tree (adder12s). The adder tree has no valid signal and cannot be stalled. This block does five things:
- Tracks sample validity through the tree's fixed latency.
- Converts the 15-bit signed sum into a rounded 12-bit signed average.
- Buffers averages in a small FIFO with a ready/valid output.
- Reports overflow and dropped samples.
- Tracks the min/max of accepted averages.

Parameters:
- LATENCY, 5, cycles from n0..n7 presented to the adder until the matching sum is valid at its output.
- DEPTH, 4, FIFO entries; must be a power of 2, at least 2.

Ports:
- clk  in  1  rising-edge clock, the same clock as adder12s.
- rst  in  1  synchronous, active-high reset.
- in_valid  in  1  high in the cycle n0..n7 are presented to adder12s.
- sum  in  15  signed sum from adder12s.
- out_data  out  12  signed average at the FIFO head.
- out_valid  out  1  FIFO non-empty.
- out_ready  in  1  consumer accepts out_data this cycle.
- level  out  $clog2(DEPTH)+1  current FIFO occupancy.
- overflow  out  1  sticky flag: an average was dropped.
- ovf_clr  in  1  clears overflow and drop_cnt.
- drop_cnt  out  8  saturating count of dropped averages.
- peak_clr  in  1  restarts the min/max tracker.
- max_val  out  12  signed maximum since the last clear.
- min_val  out  12  signed minimum since the last clear.
- peak_valid  out  1  at least one average accepted since the last clear.

Behaviour:
- Reset (clk edge with rst=1): clear valid delay line, avg register, FIFO pointers, all flags and counters. Every output reads 0 while rst is held and after release. Averages in flight are discarded.
- Valid delay: LATENCY-deep shift register on in_valid. Tap vld_s is aligned with sum.
- Average stage (registered): when vld_s=1, avg <= (sum + 4) >>> 3. Use a 16-bit signed intermediate, then take bits [14:3] truncated to 12 bits.
  - Rounding is half toward +infinity.
  - Range is provably within [-2048, 2047], so no saturation logic is needed.
  - avg_vld <= vld_s.
- FIFO push: avg_vld=1 at a clk edge.
  - The push is accepted when the FIFO is not full, or when it is full and a pop occurs on the same edge.
  - Simultaneous push and pop: level stays unchanged and data order is preserved.
- FIFO pop: out_valid && out_ready.
  - out_data is the head entry, driven from registers; it is 0 when the FIFO is empty.
- Latency: in_valid at cycle t gives out_valid=1 at cycle t+LATENCY+2 when the FIFO is empty.
- Drop: a push that is not accepted.
  - overflow <= 1.
  - drop_cnt increments and saturates at 255.
  - The FIFO contents are unchanged.
- ovf_clr has priority over a same-cycle drop. The result of that cycle is overflow=0 and drop_cnt=0.
- Pointers wrap modulo DEPTH. level is in the range 0..DEPTH.
- Peak tracker updates on accepted pushes only; dropped averages are ignored.
  - If peak_valid=0: max_val and min_val both load the average, and peak_valid <= 1.
  - Otherwise: signed compare against each bound and replace if exceeded.
- peak_clr with no same-cycle accepted push: peak_valid <= 0. max_val and min_val hold their values.
- peak_clr with a same-cycle accepted push: the tracker loads the new average, and peak_valid stays 1.
- No state machine beyond the FIFO full/empty state. full = (level == DEPTH), empty = (level == 0).

Decomposition:
- Package adder12s_pkg:
  - SAMPLE_W=12, SUM_W=15, ADDER_LATENCY=5, ROUND_OFS=4, AVG_SHIFT=3.
  - Shared with the adder12s wrapper and the bench.
- One sub-module avg_fifo:
  - Synchronous register-based FIFO.
  - Parameters WIDTH and DEPTH.
  - Ports: push, pop, din, dout, full, empty, level.
  - The accept-when-full-with-pop rule lives in the parent.

Test Plan:
1. Single sample, empty FIFO: in_valid=1 at cycle 10, sum=800 at cycle 15. Expect out_valid=1 at cycle 17, out_data=100, level=1, peak_valid=1, max_val=min_val=100.
2. Rounding: sum=-3 → 0; -4 → 0; -5 → -1; 16376 → 2047; -16384 → -2048; 12 → 2; 11 → 1. Check all at out_data.
3. Overflow: out_ready=0, push 5 averages (10..50). Expect level=4, overflow=1, drop_cnt=1. Then set out_ready=1 and expect out_data 10, 20, 30, 40 in order, with level returning to 0.
4. Full plus simultaneous push/pop: FIFO full, out_ready=1, avg_vld=1 on the same edge. Expect no drop, level stays 4, the new value is at the tail, drop_cnt unchanged.
5. Peak and clear: push averages -7, 300, 12. Expect max_val=300, min_val=-7. Then peak_clr with a same-cycle push of 5: expect max_val=min_val=5, peak_valid=1. Then ovf_clr during a drop: overflow=0, drop_cnt=0.
6. Reset mid-operation: 3 samples in flight and 2 in the FIFO, assert rst for one cycle. Expect all outputs 0 afterwards and no spurious out_valid from the in-flight samples.

Source files
------------

// File: rtl/adder12s_pkg.sv
// adder12s_pkg: shared widths and constants for the adder12s tree and its consumers
package adder12s_pkg;
  localparam int SAMPLE_W = 12;
  localparam int SUM_W = 15;
  localparam int ADDER_LATENCY = 5;
  localparam int ROUND_OFS = 4;
  localparam int AVG_SHIFT = 3;
endpackage

// File: rtl/avg_fifo.sv
// avg_fifo: register-based synchronous FIFO; caller must not push when full unless also popping
module avg_fifo #(
  parameter int WIDTH = 12,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic                     pop,
  input  logic [WIDTH-1:0]         din,
  output logic [WIDTH-1:0]         dout,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   level
);
  localparam int AW = $clog2(DEPTH);
  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0] wp, rp;
  logic do_pop;
  assign empty = level == '0;
  assign full = level == (AW+1)'(DEPTH);
  assign do_pop = pop && !empty;
  assign dout = empty ? '0 : mem[rp];
  always_ff @(posedge clk)
    if (push) mem[wp] <= din;
  always_ff @(posedge clk) begin
    if (rst) begin
      wp <= '0;
      rp <= '0;
      level <= '0;
    end else begin
      if (push) wp <= wp + 1'b1;
      if (do_pop) rp <= rp + 1'b1;
      level <= level + (AW+1)'(push) - (AW+1)'(do_pop);
    end
  end
endmodule

// File: rtl/adder12s_avg_out.sv
// adder12s_avg_out: validity tracking, rounded average, output FIFO, drop and peak reporting for adder12s
module adder12s_avg_out import adder12s_pkg::*; #(
  parameter int LATENCY = ADDER_LATENCY,
  parameter int DEPTH = 4
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        in_valid,
  input  logic signed [SUM_W-1:0]     sum,
  output logic signed [SAMPLE_W-1:0]  out_data,
  output logic                        out_valid,
  input  logic                        out_ready,
  output logic [$clog2(DEPTH):0]      level,
  output logic                        overflow,
  input  logic                        ovf_clr,
  output logic [7:0]                  drop_cnt,
  input  logic                        peak_clr,
  output logic signed [SAMPLE_W-1:0]  max_val,
  output logic signed [SAMPLE_W-1:0]  min_val,
  output logic                        peak_valid
);
  logic [LATENCY-1:0] vld_sr;
  logic vld_s, avg_vld, full, empty, pop, accept, drop;
  logic signed [SUM_W:0] rnd;
  logic signed [SAMPLE_W-1:0] avg;
  assign vld_s = vld_sr[LATENCY-1];
  assign rnd = {sum[SUM_W-1], sum} + (SUM_W+1)'(ROUND_OFS);
  assign out_valid = !empty;
  assign pop = out_valid && out_ready;
  // a full FIFO still takes the new average when the head leaves on the same edge
  assign accept = avg_vld && (!full || pop);
  assign drop = avg_vld && !accept;
  always_ff @(posedge clk) begin
    if (rst) begin
      vld_sr <= '0;
      avg <= '0;
      avg_vld <= 1'b0;
    end else begin
      vld_sr <= (vld_sr << 1) | LATENCY'(in_valid);
      avg <= vld_s ? SAMPLE_W'(rnd >>> AVG_SHIFT) : avg;
      avg_vld <= vld_s;
    end
  end
  always_ff @(posedge clk) begin
    if (rst || ovf_clr) begin
      overflow <= 1'b0;
      drop_cnt <= '0;
    end else if (drop) begin
      overflow <= 1'b1;
      drop_cnt <= drop_cnt + 8'(drop_cnt != 8'hff);
    end
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      peak_valid <= 1'b0;
      max_val <= '0;
      min_val <= '0;
    end else if (accept) begin
      peak_valid <= 1'b1;
      max_val <= (!peak_valid || peak_clr || avg > max_val) ? avg : max_val;
      min_val <= (!peak_valid || peak_clr || avg < min_val) ? avg : min_val;
    end else if (peak_clr) begin
      peak_valid <= 1'b0;
    end
  end
  avg_fifo #(.WIDTH(SAMPLE_W), .DEPTH(DEPTH)) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (accept),
    .pop   (pop),
    .din   (avg),
    .dout  (out_data),
    .full  (full),
    .empty (empty),
    .level (level)
  );
endmodule

// File: tb/tb_adder12s_avg_out.sv
// tb_adder12s_avg_out: directed plan plus randomized traffic checked against a queue-based model
module tb_adder12s_avg_out;
  import adder12s_pkg::*;
  localparam int L = ADDER_LATENCY;
  localparam int DEPTH = 4;
  logic clk = 0, rst = 1, in_valid = 0, out_ready = 0, ovf_clr = 0, peak_clr = 0;
  logic signed [SUM_W-1:0] sum = '0;
  logic signed [SAMPLE_W-1:0] out_data, max_val, min_val;
  logic out_valid, overflow, peak_valid;
  logic [$clog2(DEPTH):0] level;
  logic [7:0] drop_cnt;
  int n_cmp = 0, n_bad = 0;
  int cyc = 0, last_rst = -1000;
  bit chk_en = 0;
  int sum_at[int];
  bit hist[int];
  int q[$];
  int m_avg = 0, m_drop = 0, m_max = 0, m_min = 0;
  bit m_avg_vld = 0, m_ovf = 0, m_pv = 0;
  int rs[7] = '{-3, -4, -5, 16376, -16384, 12, 11};
  int re[7] = '{0, 0, -1, 2047, -2048, 2, 1};
  int t4[4] = '{2, 3, 4, 99};

  adder12s_avg_out #(.LATENCY(L), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .sum(sum), .out_data(out_data),
    .out_valid(out_valid), .out_ready(out_ready), .level(level), .overflow(overflow),
    .ovf_clr(ovf_clr), .drop_cnt(drop_cnt), .peak_clr(peak_clr), .max_val(max_val),
    .min_val(min_val), .peak_valid(peak_valid)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s cycle %0d: got %0d expected %0d", name, cyc, act, exp);
    end
  endtask

  task automatic chk_zero(input string p);
    chk({p, "_valid"}, out_valid, 0);
    chk({p, "_data"}, out_data, 0);
    chk({p, "_level"}, level, 0);
    chk({p, "_ovf"}, overflow, 0);
    chk({p, "_drop"}, drop_cnt, 0);
    chk({p, "_pv"}, peak_valid, 0);
    chk({p, "_max"}, max_val, 0);
    chk({p, "_min"}, min_val, 0);
  endtask

  // advance to the next cycle; a valid sample schedules its sum L cycles later
  task automatic tick(input bit v, input int s);
    @(negedge clk);
    in_valid = v;
    if (v) sum_at[cyc + L] = s;
    sum = sum_at.exists(cyc) ? SUM_W'(sum_at[cyc]) : SUM_W'($urandom);
  endtask

  // model: a sample issued at cycle c yields floor((sum+4)/8) entering the queue at the end of c+L+1
  always @(posedge clk) begin
    int s;
    bit vs, pop, acc;
    if (rst) begin
      q.delete();
      m_avg_vld = 0; m_ovf = 0; m_drop = 0; m_pv = 0; m_max = 0; m_min = 0;
      last_rst = cyc;
    end else begin
      pop = q.size() > 0 && out_ready;
      acc = m_avg_vld && (q.size() < DEPTH || pop);
      if (pop) void'(q.pop_front());
      if (acc) begin
        q.push_back(m_avg);
        if (!m_pv || peak_clr) begin m_max = m_avg; m_min = m_avg; end
        else begin
          if (m_avg > m_max) m_max = m_avg;
          if (m_avg < m_min) m_min = m_avg;
        end
        m_pv = 1;
      end else if (peak_clr) m_pv = 0;
      if (ovf_clr) begin m_ovf = 0; m_drop = 0; end
      else if (m_avg_vld && !acc) begin m_ovf = 1; m_drop = m_drop < 255 ? m_drop + 1 : 255; end
      vs = (cyc - L > last_rst) && hist.exists(cyc - L) && hist[cyc - L];
      if (vs) begin s = sum; m_avg = (s + 4) >>> 3; end
      m_avg_vld = vs;
    end
    hist[cyc] = in_valid;
    cyc++;
  end

  always @(negedge clk) if (chk_en) begin
    chk("m_valid", out_valid, q.size() > 0);
    chk("m_data", out_data, q.size() > 0 ? q[0] : 0);
    chk("m_level", level, q.size());
    chk("m_ovf", overflow, m_ovf);
    chk("m_drop", drop_cnt, m_drop);
    chk("m_pv", peak_valid, m_pv);
    chk("m_max", max_val, m_max);
    chk("m_min", min_val, m_min);
  end

  initial begin
    repeat (3) tick(0, 0);
    chk_zero("rst_hold");
    rst = 0;
    chk_en = 1;
    // single sample latency and value
    tick(1, 800);
    repeat (L + 1) tick(0, 0);
    chk("t1_early", out_valid, 0);
    tick(0, 0);
    chk("t1_valid", out_valid, 1);
    chk("t1_data", out_data, 100);
    chk("t1_level", level, 1);
    chk("t1_pv", peak_valid, 1);
    chk("t1_max", max_val, 100);
    chk("t1_min", min_val, 100);
    out_ready = 1;
    tick(0, 0);
    // rounding corners, streamed through an always-ready consumer
    foreach (rs[i]) tick(1, rs[i]);
    repeat (L - 4) tick(0, 0);
    foreach (re[i]) begin
      chk("t2_round", out_data, re[i]);
      tick(0, 0);
    end
    // overflow: five averages into four slots
    out_ready = 0;
    for (int i = 0; i < 5; i++) tick(1, 80 * (i + 1));
    repeat (L + 2) tick(0, 0);
    chk("t3_level", level, 4);
    chk("t3_ovf", overflow, 1);
    chk("t3_drop", drop_cnt, 1);
    out_ready = 1;
    for (int i = 0; i < 4; i++) begin
      chk("t3_order", out_data, 10 * (i + 1));
      tick(0, 0);
    end
    chk("t3_empty", level, 0);
    chk("t3_novalid", out_valid, 0);
    // full FIFO with push and pop on the same edge
    out_ready = 0;
    for (int i = 0; i < 4; i++) tick(1, 8 * (i + 1));
    tick(1, 792);
    repeat (L + 1) tick(0, 0);
    chk("t4_full", level, 4);
    chk("t4_head", out_data, 1);
    out_ready = 1;
    tick(0, 0);
    out_ready = 0;
    chk("t4_level", level, 4);
    chk("t4_drop", drop_cnt, 1);
    chk("t4_head2", out_data, 2);
    out_ready = 1;
    foreach (t4[i]) begin
      chk("t4_drain", out_data, t4[i]);
      tick(0, 0);
    end
    // peak tracking and clears
    peak_clr = 1;
    tick(0, 0);
    peak_clr = 0;
    chk("t5_pvclr", peak_valid, 0);
    tick(1, -56);
    tick(1, 2400);
    tick(1, 96);
    repeat (L + 3) tick(0, 0);
    chk("t5_max", max_val, 300);
    chk("t5_min", min_val, -7);
    tick(1, 40);
    repeat (L + 1) tick(0, 0);
    peak_clr = 1;
    tick(0, 0);
    peak_clr = 0;
    chk("t5_max5", max_val, 5);
    chk("t5_min5", min_val, 5);
    chk("t5_pv", peak_valid, 1);
    tick(0, 0);
    out_ready = 0;
    for (int i = 0; i < 5; i++) tick(1, 8);
    repeat (L + 1) tick(0, 0);
    chk("t5_ovf_pre", overflow, 1);
    ovf_clr = 1;
    tick(0, 0);
    ovf_clr = 0;
    chk("t5_ovfclr", overflow, 0);
    chk("t5_dropclr", drop_cnt, 0);
    chk("t5_lvl", level, 4);
    // reset with entries queued and samples in flight
    out_ready = 1;
    repeat (4) tick(0, 0);
    out_ready = 0;
    tick(1, 160);
    tick(1, 240);
    repeat (L - 1) tick(0, 0);
    repeat (3) tick(1, 320);
    tick(0, 0);
    chk("t6_level", level, 2);
    rst = 1;
    tick(0, 0);
    rst = 0;
    chk_zero("t6_post");
    repeat (L + 3) begin
      tick(0, 0);
      chk("t6_quiet", out_valid, 0);
    end
    // randomized traffic
    for (int i = 0; i < 2000; i++) begin
      tick($urandom_range(0, 9) < 6, int'($urandom_range(0, 32760)) - 16384);
      out_ready = $urandom_range(0, 2) != 0;
      ovf_clr = $urandom_range(0, 49) == 0;
      peak_clr = $urandom_range(0, 39) == 0;
      rst = $urandom_range(0, 399) == 0;
    end
    rst = 0;
    tick(0, 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
